// File: rtl/experiment_sequencer_pkg.sv
// Shared constants and configuration types for the experiment sequencer.
// Contents: mux opcodes, FSM state enum, command-word builder.
package experiment_sequencer_pkg;

  // Opcodes carried in command[15:0]
  localparam logic [15:0] WRITE_OP    = 16'h0001;
  localparam logic [15:0] READ_RESULT = 16'h0002;

  typedef enum logic [2:0] {
    IDLE, WRITE, SETTLE, READ, CAPTURE, OUTPUT, DONE
  } seq_state_t;

  // Command word layout: {index[31:24], frame id[23:16], opcode[15:0]}
  function automatic logic [31:0] mk_cmd(input logic [7:0] idx,
                                         input logic [7:0] frame,
                                         input logic [15:0] op);
    return {idx, frame, op};
  endfunction

endpackage

// File: rtl/experiment_sequencer_operand_buffer.sv
// operand_buffer: DEPTH x 32-bit register file, one write port, combinational read.
// Ports: clk, reset_n (async low, clears all entries), wr_en/wr_idx/wr_data write
// port (out-of-range indices match no entry and are dropped), rd_idx -> rd_data
// (reads 0 for out-of-range indices).
module operand_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [7:0]  rd_idx,
  output logic [31:0] rd_data
);

  logic [DEPTH-1:0][31:0] mem;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          mem[g] <= '0;
      else if (wr_en && wr_idx == 8'(g))     mem[g] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_idx == 8'(i)) rd_data = mem[i];
  end

endmodule

// File: rtl/experiment_sequencer.sv
// experiment_sequencer: writes OPERAND_COUNT operands to the experiment data mux,
// waits settle_cycles, then reads RESULT_COUNT results back and streams them out
// over a valid/ready port.
// Ports: clk, reset_n (async low); start, settle_cycles; op_wr_en/idx/data operand
// load (IDLE only); busy, done; mux_commit/mux_command/mux_data_in command port,
// mux_data_out read data (one cycle after a read commit); res_valid/res_ready/
// res_data/res_index result stream.
module experiment_sequencer
  import experiment_sequencer_pkg::*;
#(
  parameter int         OPERAND_COUNT = 2,
  parameter int         RESULT_COUNT  = 1,
  parameter logic [7:0] FRAME_ID      = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] settle_cycles,
  input  logic        op_wr_en,
  input  logic [7:0]  op_wr_idx,
  input  logic [31:0] op_wr_data,
  output logic        busy,
  output logic        done,
  output logic        mux_commit,
  output logic [31:0] mux_command,
  output logic [31:0] mux_data_in,
  input  logic [31:0] mux_data_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [7:0]  res_index
);

  localparam logic [7:0] LAST_OP  = 8'(OPERAND_COUNT - 1);
  localparam logic [7:0] LAST_RES = 8'(RESULT_COUNT - 1);

  seq_state_t  state;
  logic [7:0]  index;
  logic [15:0] settle_cnt;
  logic        buf_wr;
  logic [7:0]  rd_idx;
  logic [31:0] rd_data;
  logic [31:0] first_op;

  assign buf_wr = op_wr_en && (state == IDLE);

  // Outputs are registered, so the buffer is read one entry ahead of the
  // commit being presented: entry 0 on the start edge, index+1 during WRITE.
  assign rd_idx = (state == IDLE) ? 8'd0 : index + 8'd1;

  // A write to entry 0 on the start edge has not landed in the buffer yet;
  // forward it so the run uses the new value.
  assign first_op = (buf_wr && op_wr_idx == 8'd0) ? op_wr_data : rd_data;

  operand_buffer #(.DEPTH(OPERAND_COUNT)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (buf_wr),
    .wr_idx  (op_wr_idx),
    .wr_data (op_wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      index       <= '0;
      settle_cnt  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mux_commit  <= 1'b0;
      mux_command <= '0;
      mux_data_in <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_index   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          settle_cnt  <= settle_cycles;
          index       <= '0;
          busy        <= 1'b1;
          mux_commit  <= 1'b1;
          mux_command <= mk_cmd(8'd0, FRAME_ID, WRITE_OP);
          mux_data_in <= first_op;
          state       <= WRITE;
        end
        WRITE: begin
          if (index == LAST_OP) begin
            index <= '0;
            if (settle_cnt == '0) begin
              mux_command <= mk_cmd(8'd0, FRAME_ID, READ_RESULT);
              mux_data_in <= '0;
              state       <= READ;
            end else begin
              mux_commit  <= 1'b0;
              mux_command <= '0;
              mux_data_in <= '0;
              state       <= SETTLE;
            end
          end else begin
            index       <= index + 8'd1;
            mux_command <= mk_cmd(index + 8'd1, FRAME_ID, WRITE_OP);
            mux_data_in <= rd_data;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 16'd1;
          if (settle_cnt == 16'd1) begin
            mux_commit  <= 1'b1;
            mux_command <= mk_cmd(index, FRAME_ID, READ_RESULT);
            state       <= READ;
          end
        end
        READ: begin
          mux_commit  <= 1'b0;
          mux_command <= '0;
          mux_data_in <= '0;
          state       <= CAPTURE;
        end
        CAPTURE: begin
          res_data  <= mux_data_out;
          res_index <= index;
          res_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: if (res_ready) begin
          res_valid <= 1'b0;
          if (index == LAST_RES) begin
            index <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            index       <= index + 8'd1;
            mux_commit  <= 1'b1;
            mux_command <= mk_cmd(index + 8'd1, FRAME_ID, READ_RESULT);
            state       <= READ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_experiment_sequencer.sv
// Self-checking bench for experiment_sequencer (OPERAND_COUNT=2, RESULT_COUNT=2).
// Expected mux commits, results and done pulses are queued when a run is started
// and popped by a monitor as the DUT produces them; a small mux model returns
// per-index read data one cycle after each read commit.
module tb_experiment_sequencer;

  localparam logic [7:0]  FID  = 8'hA5;
  localparam logic [15:0] OP_W = 16'h0001;
  localparam logic [15:0] OP_R = 16'h0002;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] settle_cycles = '0;
  logic        op_wr_en = 1'b0;
  logic [7:0]  op_wr_idx = '0;
  logic [31:0] op_wr_data = '0;
  logic        busy, done, mux_commit;
  logic [31:0] mux_command, mux_data_in;
  logic [31:0] mux_data_out = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [7:0]  res_index;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [31:0] rdval [2];

  typedef struct { logic [31:0] cmd; logic [31:0] data; int at; } commit_t;
  typedef struct { logic [31:0] data; logic [7:0] idx; } result_t;
  typedef struct { logic [31:0] w0; logic [31:0] w1; logic [15:0] settle;
                   logic [31:0] rd0; logic [31:0] rd1; int stall; } vec_t;

  commit_t cq[$];
  result_t rq[$];
  int      dq[$];
  vec_t    vecs[4];

  experiment_sequencer #(.OPERAND_COUNT(2), .RESULT_COUNT(2), .FRAME_ID(FID)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .settle_cycles(settle_cycles),
    .op_wr_en(op_wr_en), .op_wr_idx(op_wr_idx), .op_wr_data(op_wr_data),
    .busy(busy), .done(done), .mux_commit(mux_commit), .mux_command(mux_command),
    .mux_data_in(mux_data_in), .mux_data_out(mux_data_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_index(res_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mux model: registered read data, valid the cycle after a read commit
  always @(posedge clk)
    if (mux_commit && mux_command[15:0] == OP_R) mux_data_out <= rdval[mux_command[24]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    commit_t c;
    result_t r;
    int      d;
    #1;
    if (mon_en) begin
      if (mux_commit) begin
        if (cq.size() == 0) unexpected("commit", mux_command);
        else begin
          c = cq.pop_front();
          chk("commit_cmd", mux_command, c.cmd);
          chk("commit_data", mux_data_in, c.data);
          chk("commit_cycle", 32'(cyc), 32'(c.at));
        end
      end else begin
        chk("idle_bus", mux_command | mux_data_in, 32'h0);
      end
      if (res_valid) begin
        if (rq.size() == 0) unexpected("result", res_data);
        else begin
          r = rq[0];
          chk("res_data", res_data, r.data);
          chk("res_index", {24'h0, res_index}, {24'h0, r.idx});
          if (res_ready) void'(rq.pop_front());
        end
      end
      if (done) begin
        if (dq.size() == 0) unexpected("done", 32'(cyc));
        else begin
          d = dq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(d));
        end
      end
    end
  end

  task automatic wr(input logic [7:0] i, input logic [31:0] d);
    op_wr_en = 1'b1; op_wr_idx = i; op_wr_data = d;
    @(negedge clk);
    op_wr_en = 1'b0;
  endtask

  // Starts a run at the current negedge and follows it to completion.
  // Timing relative to the start edge: writes at 1,2; first read at s+3;
  // result valid at s+5; ready rises k cycles later; second read one cycle
  // after that handshake; done at s+9+k; busy falls at s+10+k.
  task automatic do_run(input logic [31:0] e0, input logic [31:0] e1, input logic [15:0] s,
                        input logic [31:0] r0, input logic [31:0] r1, input int k,
                        input bit disturb, input bit sw_en, input logic [7:0] sw_idx,
                        input logic [31:0] sw_data);
    int t0, fin;
    commit_t c;
    result_t r;
    t0  = cyc;
    fin = int'(s) + 9 + k;
    rdval[0] = r0; rdval[1] = r1; settle_cycles = s;
    c.cmd = {8'h00, FID, OP_W}; c.data = e0;   c.at = t0 + 1;             cq.push_back(c);
    c.cmd = {8'h01, FID, OP_W}; c.data = e1;   c.at = t0 + 2;             cq.push_back(c);
    c.cmd = {8'h00, FID, OP_R}; c.data = '0;   c.at = t0 + int'(s) + 3;     cq.push_back(c);
    c.cmd = {8'h01, FID, OP_R}; c.data = '0;   c.at = t0 + int'(s) + 6 + k; cq.push_back(c);
    r.data = r0; r.idx = 8'd0; rq.push_back(r);
    r.data = r1; r.idx = 8'd1; rq.push_back(r);
    dq.push_back(t0 + fin);
    start = 1'b1; res_ready = 1'b0;
    if (sw_en) begin op_wr_en = 1'b1; op_wr_idx = sw_idx; op_wr_data = sw_data; end
    for (int rel = 1; rel <= fin + 1; rel++) begin
      @(negedge clk);
      start = 1'b0; op_wr_en = 1'b0;
      res_ready = (rel >= int'(s) + 5 + k);
      if (disturb && (rel == 3 || rel == 4)) begin
        start = 1'b1; op_wr_en = 1'b1; op_wr_idx = 8'd0; op_wr_data = 32'hBAD0_BAD0;
      end
      chk("busy", {31'h0, busy}, {31'h0, rel <= fin});
    end
    start = 1'b0; op_wr_en = 1'b0; res_ready = 1'b0;
    chk("commits_left", cq.size(), 0);
    chk("results_left", rq.size(), 0);
    chk("done_left", dq.size(), 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{32'h0000_0011, 32'h0000_0022, 16'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4};
    vecs[1] = '{32'h0000_0033, 32'h0000_0044, 16'd0, 32'h1357_9BDF, 32'h2468_ACE0, 0};
    vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 16'd1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 16'd2, 32'h8000_0001, 32'h7FFF_FFFE, 0};
    rdval[0] = '0; rdval[1] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_commit", {31'h0, mux_commit}, 32'h0);
    chk("rst_command", mux_command, 32'h0);
    chk("rst_data_in", mux_data_in, 32'h0);
    chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_res_index", {24'h0, res_index}, 32'h0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    // Table-driven runs
    for (int v = 0; v < 4; v++) begin
      wr(8'd0, vecs[v].w0);
      wr(8'd1, vecs[v].w1);
      do_run(vecs[v].w0, vecs[v].w1, vecs[v].settle, vecs[v].rd0, vecs[v].rd1,
             vecs[v].stall, 1'b0, 1'b0, 8'd0, 32'h0);
    end

    // start and operand write while busy are ignored; next run shows unchanged buffer
    do_run(vecs[3].w0, vecs[3].w1, 16'd3, 32'hAAAA_0001, 32'hAAAA_0002, 1,
           1'b1, 1'b0, 8'd0, 32'h0);
    // out-of-range write index is dropped
    wr(8'd5, 32'h5555_5555);
    do_run(vecs[3].w0, vecs[3].w1, 16'd1, 32'hBBBB_0001, 32'hBBBB_0002, 0,
           1'b0, 1'b0, 8'd0, 32'h0);
    // write coinciding with start lands first (entry 0, then entry 1)
    do_run(32'h0000_0066, vecs[3].w1, 16'd0, 32'hCCCC_0001, 32'hCCCC_0002, 0,
           1'b0, 1'b1, 8'd0, 32'h0000_0066);
    do_run(32'h0000_0066, 32'h0000_0077, 16'd2, 32'hDDDD_0001, 32'hDDDD_0002, 2,
           1'b0, 1'b1, 8'd1, 32'h0000_0077);

    // Reset while holding a result in OUTPUT
    wr(8'd0, 32'h0000_00A1);
    wr(8'd1, 32'h0000_00A2);
    mon_en = 1'b0;
    rdval[0] = 32'hEEEE_0001; rdval[1] = 32'hEEEE_0002;
    settle_cycles = 16'd1; res_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!res_valid && n < 40) begin @(negedge clk); n++; end
    chk("wait_res_valid", {31'h0, res_valid}, 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_res_valid", {31'h0, res_valid}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_commit", {31'h0, mux_commit}, 32'h0);
    chk("midrst_res_data", res_data, 32'h0);
    @(negedge clk);
    cq.delete(); rq.delete(); dq.delete();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    // start on the first edge after release; operands were cleared by reset
    do_run(32'h0, 32'h0, 16'd2, 32'h4242_0001, 32'h4242_0002, 1,
           1'b0, 1'b0, 8'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
